// File: rtl/nand_cpu_pkg.sv
// Shared rename-snapshot types for the branch checkpoint table.
// Register-file sizes come from NUM_D_REG / NUM_S_REG / ROB_LENGTH if the build defines them.
`ifndef NUM_D_REG
`define NUM_D_REG 32
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 8
`endif
`ifndef ROB_LENGTH
`define ROB_LENGTH 16
`endif

package nand_cpu_pkg;
    localparam int NUM_CP_DEFAULT = 4;
    localparam int D_REGS  = `NUM_D_REG;
    localparam int S_REGS  = `NUM_S_REG;
    localparam int ROB_LEN = `ROB_LENGTH;
    localparam int CP_TW   = $clog2(NUM_CP_DEFAULT);
    localparam int DREG_W  = $clog2(D_REGS);
    localparam int SREG_W  = $clog2(S_REGS);
    localparam int ROB_W   = $clog2(ROB_LEN);

    typedef logic [CP_TW-1:0] cp_tag_t;

    typedef struct packed {
        logic [D_REGS-1:0]    r_free;
        logic [S_REGS-1:0]    s_free;
        logic [16*DREG_W-1:0] d_trans;
        logic [SREG_W-1:0]    s_trans;
        logic [ROB_W-1:0]     rob_tail;
    } cp_entry_t;
endpackage

// File: rtl/bct_entry.sv
// One rename snapshot slot; keeps its free lists current with registers freed by commit.
module bct_entry
    import nand_cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  cp_entry_t         wr_data,
    input  logic              fix_en,
    input  logic              d_free_valid,
    input  logic [DREG_W-1:0] d_free_preg,
    input  logic              s_free_valid,
    input  logic [SREG_W-1:0] s_free_preg,
    output cp_entry_t         data
);
    cp_entry_t nxt;

    // A snapshot being written this cycle must also see this cycle's frees.
    always_comb begin
        nxt = wr_en ? wr_data : data;
        if (fix_en || wr_en) begin
            if (d_free_valid) nxt.r_free[d_free_preg] = 1'b1;
            if (s_free_valid) nxt.s_free[s_free_preg] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) data <= '0;
        else     data <= nxt;
    end
endmodule

// File: rtl/branch_checkpoint_table.sv
// Circular table of per-branch rename snapshots with zero-latency mispredict recovery.
// Optional BCT_PERF_EN adds saturating mispredict / full-stall counters.
module branch_checkpoint_table
    import nand_cpu_pkg::*;
#(
    parameter int NUM_CP     = NUM_CP_DEFAULT,
    parameter int NUM_D_REG  = D_REGS,
    parameter int NUM_S_REG  = S_REGS,
    parameter int ROB_LENGTH = ROB_LEN
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            alloc_req,
    input  logic [NUM_D_REG-1:0]            snap_r_free_list,
    input  logic [NUM_S_REG-1:0]            snap_s_free_list,
    input  logic [16*$clog2(NUM_D_REG)-1:0] snap_d_translation,
    input  logic [$clog2(NUM_S_REG)-1:0]    snap_s_translation,
    input  logic [$clog2(ROB_LENGTH)-1:0]   snap_rob_tail,
    output logic                            alloc_ack,
    output logic [$clog2(NUM_CP)-1:0]       alloc_tag,
    output logic                            full,
    input  logic                            resolve_valid,
    input  logic [$clog2(NUM_CP)-1:0]       resolve_tag,
    input  logic                            resolve_mispredict,
    input  logic                            commit_d_free_valid,
    input  logic [$clog2(NUM_D_REG)-1:0]    commit_d_free_preg,
    input  logic                            commit_s_free_valid,
    input  logic [$clog2(NUM_S_REG)-1:0]    commit_s_free_preg,
    output logic                            recover_valid,
    output logic [NUM_D_REG-1:0]            frl_r_free_list_cp,
    output logic [NUM_S_REG-1:0]            frl_s_free_list_cp,
    output logic [16*$clog2(NUM_D_REG)-1:0] tt_d_translation_cp,
    output logic [$clog2(NUM_S_REG)-1:0]    tt_s_translation_cp,
    output logic [$clog2(ROB_LENGTH)-1:0]   rob_tail_cp
`ifdef BCT_PERF_EN
    ,
    output logic [31:0]                     perf_mispredicts,
    output logic [31:0]                     perf_full_stalls
`endif
);
    localparam int TAG_W = $clog2(NUM_CP);

    logic [NUM_CP-1:0] valid, valid_nxt;
    logic [TAG_W-1:0]  head, tail, tag_off, off_i;
    logic [TAG_W:0]    count;
    logic              mp, ok_res, retire;
    cp_entry_t         snap, sel;
    cp_entry_t         ent [NUM_CP];

    assign full      = (count == (TAG_W+1)'(NUM_CP));
    assign mp        = resolve_valid & resolve_mispredict & valid[resolve_tag];
    assign ok_res    = resolve_valid & ~resolve_mispredict & valid[resolve_tag];
    assign alloc_ack = alloc_req & ~full & ~mp;
    assign alloc_tag = tail;
    assign tag_off   = resolve_tag - head;

    assign snap = '{r_free:   snap_r_free_list,
                    s_free:   snap_s_free_list,
                    d_trans:  snap_d_translation,
                    s_trans:  snap_s_translation,
                    rob_tail: snap_rob_tail};

    // Flush range is measured as an age offset from head, so a full table
    // (head == tail) flushes correctly from resolve_tag to the youngest entry.
    always_comb begin
        valid_nxt = valid;
        off_i     = '0;
        if (alloc_ack) valid_nxt[tail] = 1'b1;
        if (ok_res)    valid_nxt[resolve_tag] = 1'b0;
        if (mp) begin
            for (int i = 0; i < NUM_CP; i++) begin
                off_i = TAG_W'(i) - head;
                if (off_i >= tag_off && {1'b0, off_i} < count) valid_nxt[i] = 1'b0;
            end
        end
        retire = !mp && (count != '0) && !valid_nxt[head];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            valid <= valid_nxt;
            if (mp) begin
                tail  <= resolve_tag;
                count <= {1'b0, tag_off};
            end else begin
                if (alloc_ack) tail <= tail + 1'b1;
                if (retire)    head <= head + 1'b1;
                count <= count + {{TAG_W{1'b0}}, alloc_ack} - {{TAG_W{1'b0}}, retire};
            end
        end
    end

    for (genvar g = 0; g < NUM_CP; g++) begin : g_entry
        bct_entry u_entry (
            .clk          (clk),
            .rst          (rst),
            .wr_en        (alloc_ack && (tail == TAG_W'(g))),
            .wr_data      (snap),
            .fix_en       (valid[g]),
            .d_free_valid (commit_d_free_valid),
            .d_free_preg  (commit_d_free_preg),
            .s_free_valid (commit_s_free_valid),
            .s_free_preg  (commit_s_free_preg),
            .data         (ent[g])
        );
    end

    always_comb begin
        sel                = ent[resolve_tag];
        frl_r_free_list_cp = sel.r_free;
        frl_s_free_list_cp = sel.s_free;
        if (commit_d_free_valid) frl_r_free_list_cp[commit_d_free_preg] = 1'b1;
        if (commit_s_free_valid) frl_s_free_list_cp[commit_s_free_preg] = 1'b1;
        tt_d_translation_cp = sel.d_trans;
        tt_s_translation_cp = sel.s_trans;
        rob_tail_cp         = sel.rob_tail;
    end

    assign recover_valid = mp;

`ifdef BCT_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_mispredicts <= '0;
            perf_full_stalls <= '0;
        end else begin
            if (mp && perf_mispredicts != '1)
                perf_mispredicts <= perf_mispredicts + 32'd1;
            if (alloc_req && full && perf_full_stalls != '1)
                perf_full_stalls <= perf_full_stalls + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_checkpoint_table.sv
// Self-checking bench for branch_checkpoint_table: vector table plus hand-written corner sequences.
module tb_branch_checkpoint_table;
    import nand_cpu_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    alloc_req;
    logic [D_REGS-1:0]       snap_r_free_list;
    logic [S_REGS-1:0]       snap_s_free_list;
    logic [16*DREG_W-1:0]    snap_d_translation;
    logic [SREG_W-1:0]       snap_s_translation;
    logic [ROB_W-1:0]        snap_rob_tail;
    logic                    alloc_ack;
    logic [CP_TW-1:0]        alloc_tag;
    logic                    full;
    logic                    resolve_valid;
    logic [CP_TW-1:0]        resolve_tag;
    logic                    resolve_mispredict;
    logic                    commit_d_free_valid;
    logic [DREG_W-1:0]       commit_d_free_preg;
    logic                    commit_s_free_valid;
    logic [SREG_W-1:0]       commit_s_free_preg;
    logic                    recover_valid;
    logic [D_REGS-1:0]       frl_r_free_list_cp;
    logic [S_REGS-1:0]       frl_s_free_list_cp;
    logic [16*DREG_W-1:0]    tt_d_translation_cp;
    logic [SREG_W-1:0]       tt_s_translation_cp;
    logic [ROB_W-1:0]        rob_tail_cp;
`ifdef BCT_PERF_EN
    logic [31:0]             perf_mispredicts;
    logic [31:0]             perf_full_stalls;
`endif

    always #5 clk = ~clk;

    branch_checkpoint_table dut (
        .clk                 (clk),
        .rst                 (rst),
        .alloc_req           (alloc_req),
        .snap_r_free_list    (snap_r_free_list),
        .snap_s_free_list    (snap_s_free_list),
        .snap_d_translation  (snap_d_translation),
        .snap_s_translation  (snap_s_translation),
        .snap_rob_tail       (snap_rob_tail),
        .alloc_ack           (alloc_ack),
        .alloc_tag           (alloc_tag),
        .full                (full),
        .resolve_valid       (resolve_valid),
        .resolve_tag         (resolve_tag),
        .resolve_mispredict  (resolve_mispredict),
        .commit_d_free_valid (commit_d_free_valid),
        .commit_d_free_preg  (commit_d_free_preg),
        .commit_s_free_valid (commit_s_free_valid),
        .commit_s_free_preg  (commit_s_free_preg),
        .recover_valid       (recover_valid),
        .frl_r_free_list_cp  (frl_r_free_list_cp),
        .frl_s_free_list_cp  (frl_s_free_list_cp),
        .tt_d_translation_cp (tt_d_translation_cp),
        .tt_s_translation_cp (tt_s_translation_cp),
        .rob_tail_cp         (rob_tail_cp)
`ifdef BCT_PERF_EN
        ,
        .perf_mispredicts    (perf_mispredicts),
        .perf_full_stalls    (perf_full_stalls)
`endif
    );

    typedef struct {
        logic a;   int rt;   logic rv;  int tg;   logic mp;
        logic ack; int atag; logic fl;  logic rvld; int rcp; int cnt; int hd;
    } vec_t;

    vec_t vecs [20];
    vec_t exp_q [$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic a, input int rt, input logic rv, input int tg,
                                input logic mp, input logic ack, input int atag, input logic fl,
                                input logic rvld, input int rcp, input int cnt, input int hd);
        vec_t v;
        v.a = a; v.rt = rt; v.rv = rv; v.tg = tg; v.mp = mp;
        v.ack = ack; v.atag = atag; v.fl = fl; v.rvld = rvld; v.rcp = rcp; v.cnt = cnt; v.hd = hd;
        return v;
    endfunction

    task automatic idle_inputs();
        alloc_req = 0; resolve_valid = 0; resolve_tag = '0; resolve_mispredict = 0;
        commit_d_free_valid = 0; commit_d_free_preg = '0;
        commit_s_free_valid = 0; commit_s_free_preg = '0;
        snap_r_free_list = '1; snap_s_free_list = '1;
        snap_d_translation = '0; snap_s_translation = '0; snap_rob_tail = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        alloc_req          = v.a;
        snap_rob_tail      = ROB_W'(v.rt);
        resolve_valid      = v.rv;
        resolve_tag        = CP_TW'(v.tg);
        resolve_mispredict = v.mp;
        exp_q.push_back(v);
        #1;
        e = exp_q.pop_front();
        chk("alloc_ack", 64'(alloc_ack), 64'(e.ack));
        chk("alloc_tag", 64'(alloc_tag), 64'(e.atag));
        chk("full", 64'(full), 64'(e.fl));
        chk("recover_valid", 64'(recover_valid), 64'(e.rvld));
        if (e.rcp >= 0) chk("rob_tail_cp", 64'(rob_tail_cp), 64'(e.rcp));
        @(posedge clk);
        #1;
        if (e.cnt >= 0) chk("count", 64'(dut.count), 64'(e.cnt));
        if (e.hd >= 0)  chk("head", 64'(dut.head), 64'(e.hd));
    endtask

    logic [95:0]          rnd;
    logic [16*DREG_W-1:0] exp_dt;

    initial begin
        rst = 1;
        idle_inputs();
        //            a  rt rv tg mp | ack tag fl rv rcp cnt hd
        vecs[0]  = mk(1,  5, 0, 0, 0,   1,  0, 0, 0, -1, 1, 0);
        vecs[1]  = mk(1,  6, 0, 0, 0,   1,  1, 0, 0,  5, 2, 0);
        vecs[2]  = mk(1,  7, 0, 0, 0,   1,  2, 0, 0,  5, 3, 0);
        vecs[3]  = mk(1,  8, 0, 0, 0,   1,  3, 0, 0,  5, 4, 0);
        vecs[4]  = mk(1,  9, 0, 0, 0,   0,  0, 1, 0,  5, 4, 0);
        vecs[5]  = mk(0,  0, 1, 1, 1,   0,  0, 1, 1,  6, 1, 0);
        vecs[6]  = mk(1, 10, 0, 0, 0,   1,  1, 0, 0,  5, 2, 0);
        vecs[7]  = mk(1, 11, 0, 0, 0,   1,  2, 0, 0,  5, 3, 0);
        vecs[8]  = mk(1, 12, 0, 0, 0,   1,  3, 0, 0,  5, 4, 0);
        vecs[9]  = mk(0,  0, 1, 2, 0,   0,  0, 1, 0, 11, 4, 0);
        vecs[10] = mk(0,  0, 1, 0, 0,   0,  0, 1, 0,  5, 3, 1);
        vecs[11] = mk(0,  0, 0, 0, 0,   0,  0, 0, 0,  5, 3, 1);
        vecs[12] = mk(0,  0, 1, 1, 0,   0,  0, 0, 0, 10, 2, 2);
        vecs[13] = mk(0,  0, 0, 0, 0,   0,  0, 0, 0,  5, 1, 3);
        vecs[14] = mk(1, 13, 0, 0, 0,   1,  0, 0, 0,  5, 2, 3);
        vecs[15] = mk(1, 14, 0, 0, 0,   1,  1, 0, 0, 13, 3, 3);
        vecs[16] = mk(1, 15, 1, 0, 1,   0,  2, 0, 1, 13, 1, 3);
        vecs[17] = mk(0,  0, 1, 1, 0,   0,  0, 0, 0, 14, 1, 3);
        vecs[18] = mk(0,  0, 1, 1, 1,   0,  0, 0, 0, 14, 1, 3);
        vecs[19] = mk(0,  0, 1, 3, 0,   0,  0, 0, 0, 12, 0, 0);

        do_reset();
        #1;
        chk("reset full", 64'(full), 64'd0);
        chk("reset alloc_ack", 64'(alloc_ack), 64'd0);
        chk("reset alloc_tag", 64'(alloc_tag), 64'd0);
        chk("reset recover_valid", 64'(recover_valid), 64'd0);
        chk("reset count", 64'(dut.count), 64'd0);

        for (int i = 0; i < 20; i++) apply(vecs[i]);

`ifdef BCT_PERF_EN
        chk("perf_mispredicts", 64'(perf_mispredicts), 64'd2);
        chk("perf_full_stalls", 64'(perf_full_stalls), 64'd1);
`endif

        // Commit fixup: captured with pregs 3 and 7 busy; 3 freed while writing, 7 freed later.
        do_reset();
        rnd    = {$urandom, $urandom, $urandom};
        exp_dt = rnd[16*DREG_W-1:0];
        @(negedge clk);
        alloc_req = 1; snap_rob_tail = 4'd3;
        snap_r_free_list = ~(D_REGS'(1) << 7 | D_REGS'(1) << 3);
        snap_s_free_list = '0;
        snap_d_translation = exp_dt; snap_s_translation = 3'd5;
        commit_d_free_valid = 1; commit_d_free_preg = 5'd3;
        #1 chk("fix alloc_ack", 64'(alloc_ack), 64'd1);
        @(negedge clk);
        alloc_req = 0; commit_d_free_preg = 5'd7;
        snap_r_free_list = '0; snap_d_translation = '0;
        @(negedge clk);
        commit_d_free_valid = 0;
        resolve_valid = 1; resolve_tag = 2'd0; resolve_mispredict = 1;
        commit_s_free_valid = 1; commit_s_free_preg = 3'd2;
        #1;
        chk("fix recover_valid", 64'(recover_valid), 64'd1);
        chk("fix frl_r bit7", 64'(frl_r_free_list_cp[7]), 64'd1);
        chk("fix frl_r all", 64'(frl_r_free_list_cp), 64'({D_REGS{1'b1}}));
        chk("fix frl_s", 64'(frl_s_free_list_cp), 64'h4);
        chk("fix tt_d", 64'(tt_d_translation_cp == exp_dt), 64'd1);
        chk("fix tt_s", 64'(tt_s_translation_cp), 64'd5);
        chk("fix rob_tail", 64'(rob_tail_cp), 64'd3);
        @(negedge clk);
        idle_inputs();
        #1 chk("fix flushed count", 64'(dut.count), 64'd0);

        // Asynchronous reset mid-operation drops every entry without signalling recovery.
        @(negedge clk);
        alloc_req = 1; snap_rob_tail = 4'd1;
        @(negedge clk);
        snap_rob_tail = 4'd2;
        @(negedge clk);
        alloc_req = 0;
        #1 chk("pre-reset count", 64'(dut.count), 64'd2);
        #2 rst = 1;
        resolve_valid = 1; resolve_tag = 2'd0; resolve_mispredict = 1;
        #1;
        chk("async count", 64'(dut.count), 64'd0);
        chk("async recover_valid", 64'(recover_valid), 64'd0);
        @(negedge clk);
        rst = 0;
        #1 chk("post-reset recover_valid", 64'(recover_valid), 64'd0);
        @(negedge clk);
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_checkpoint_table.md
# branch_checkpoint_table

Circular table of rename-state snapshots, one per in-flight branch, between the decoder/rename stage and the hazard controller. When a branch dispatches, it captures the free-register lists, the translation table and the ROB tail, and returns a branch tag. When the branch unit reports a mispredict, it supplies the tagged snapshot through the `branch_recovery` signal set and flushes that entry and every younger one. Correctly predicted entries are retired in order.

## Interface
Parameters:
- `NUM_CP`, 4: number of checkpoints; power of two, ≥2.
- `NUM_D_REG`, `` `NUM_D_REG ``: data physical registers.
- `NUM_S_REG`, `` `NUM_S_REG ``: status physical registers.
- `ROB_LENGTH`, `` `ROB_LENGTH ``: ROB entries.

Ports (DW = clog2(NUM_D_REG), SW = clog2(NUM_S_REG), TW = clog2(NUM_CP)):
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `alloc_req` in 1: a branch is dispatching this cycle.
- `snap_r_free_list` in NUM_D_REG: current data free list (1 = free).
- `snap_s_free_list` in NUM_S_REG: current status free list.
- `snap_d_translation` in 16×DW: current data translation table.
- `snap_s_translation` in SW: current status translation.
- `snap_rob_tail` in clog2(ROB_LENGTH): ROB tail after this branch is allocated.
- `alloc_ack` out 1: snapshot taken this cycle.
- `alloc_tag` out TW: tag of the taken snapshot.
- `full` out 1: all entries in use; the decoder stalls the branch.
- `resolve_valid` in 1: the branch unit resolves the branch `resolve_tag`.
- `resolve_tag` in TW: tag of the resolved branch.
- `resolve_mispredict` in 1: the resolved branch was mispredicted.
- `commit_d_free_valid`, `commit_d_free_preg` in 1/DW: the ROB commit frees a data register.
- `commit_s_free_valid`, `commit_s_free_preg` in 1/SW: the ROB commit frees a status register.
- `recover_valid` out 1: the recovery outputs below are valid.
- `frl_r_free_list_cp`, `frl_s_free_list_cp`, `tt_d_translation_cp`, `tt_s_translation_cp`, `rob_tail_cp` out: restored state, with the same widths as the matching `snap_*` inputs.

## Operation
- State:
  - entry array;
  - `valid[NUM_CP]`;
  - `head` (oldest) and `tail` (next allocation) pointers, each TW bits;
  - `count` (TW+1 bits).
- `full` = (`count` == NUM_CP).
- Define `mp` = `resolve_valid & resolve_mispredict & valid[resolve_tag]`.
- Allocate:
  - `alloc_ack` = `alloc_req & !full & !mp`.
  - On allocate: write the snapshot at `tail`, set `valid[tail]`, `tail` += 1 mod NUM_CP, `count` += 1.
  - `alloc_tag` = `tail` (combinational, pre-increment).
- Correct resolve (`resolve_valid & !resolve_mispredict & valid[tag]`): clear `valid[tag]`. `head` and `count` do not change here.
- Mispredict (`mp`):
  - Clear `valid` for every entry from `resolve_tag` through `tail-1` (circular).
  - Set `tail` := `resolve_tag` and `count` := (`resolve_tag` − `head`) mod NUM_CP.
  - Allocation is suppressed in the same cycle.
- Resolve on an invalid tag (already flushed or retired): ignored entirely.
- Head retire: if `count`≠0 and `!valid[head]` (after this cycle's updates), `head` += 1 and `count` −= 1.
  - At most one retire per cycle.
  - Retire does not apply in a cycle where `mp` rewrote `count`.
  - Retire can coincide with allocate; `count` changes by the net amount.
- Commit fixup:
  - For every entry with `valid`=1, OR the freed register's bit into its stored free list.
  - A snapshot written in the same cycle also receives the bit.
- Recovery outputs:
  - Combinational read of entry `resolve_tag`.
  - Same-cycle commit frees are ORed into the output free lists.
  - `recover_valid` = `mp`.
  - When `!mp`, outputs show the entry at `resolve_tag` unqualified.

## Timing
- Allocation-to-visibility is one cycle: an entry allocated in cycle N can be resolved from cycle N+1.
- Recovery is zero latency: a mispredict in cycle N drives the `*_cp` outputs in cycle N. The hazard controller restores state at the N→N+1 edge.
- A freed slot is reusable the cycle after the head passes it, or the cycle after a mispredict flush.
- Reset values: `head`=`tail`=0, `count`=0, `valid`=0.
  - Outputs: `full`=0, `alloc_ack`=0, `alloc_tag`=0, `recover_valid`=0.
  - Entry contents are don't-care; `*_cp` outputs reflect entry 0.
- Reset mid-operation: all entries are invalidated immediately (asynchronous). No recovery is signalled.
- Wrap-around: pointers wrap modulo NUM_CP. Full and empty are distinguished only by `count`.

## Configuration
- `BCT_PERF_EN` defined:
  - Two 32-bit saturating counters, `perf_mispredicts` (increments on `mp`) and `perf_full_stalls` (increments on `alloc_req & full`), are exposed as output ports.
  - Both reset to 0.
- Not defined: the counters and their ports are absent.

## Structure
- Shared package `nand_cpu_pkg`:
  - `cp_tag_t`;
  - the `cp_entry_t` struct (free lists, translations, ROB tail);
  - the `NUM_CP` default constant.
- One sub-module, `bct_entry`: stores a single snapshot, applies the commit-fixup OR, and exposes its stored value. It is instantiated NUM_CP times.

## Test plan
- Reset, then `alloc_req` with `snap_rob_tail`=5 → `alloc_ack`=1, `alloc_tag`=0; next cycle `count`=1, `full`=0.
- Allocate tags 0–3 → `full`=1; a 5th `alloc_req` → `alloc_ack`=0; `perf_full_stalls`=1 when `BCT_PERF_EN` is defined.
- Tags 0–3 in use, mispredict on tag 1 → `recover_valid`=1, `rob_tail_cp` = tag 1's snapshot; next cycle `tail`=1, `count`=1, and the next allocation gets tag 1.
- Correct resolves of tag 2 then tag 0 → `head` advances 0→1 only; after a later correct resolve of tag 1, `head` advances to 2, then 3.
- Tag 0 captured with preg 7 busy; commit frees preg 7; mispredict on tag 0 → `frl_r_free_list_cp[7]`=1.
- Same cycle `alloc_req` + mispredict on tag 2 → `alloc_ack`=0; a resolve of tag 3 next cycle is ignored.
